// File: rtl/cdr_trigger_arm_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cdr_trigger_arm_ctrl : lock-qualified arm/holdoff sequencer for CDR trigger
// Rev 1.0
// ============================================================================
module cdr_trigger_arm_ctrl #(
  parameter int LOCK_FILTER   = 8,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_mode_i,
  input  logic                     cfg_oneshot_i,
  input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff_i,
  input  logic                     arm_i,
  input  logic                     disarm_i,
  input  logic                     clear_status_i,
  input  logic                     lock_8b10b_i,
  input  logic                     lock_64b66b_i,
  input  logic                     match_valid_i,
  input  logic                     match_hit_i,
  output logic                     trig_out_o,
  output logic                     armed_o,
  output logic                     waiting_lock_o,
  output logic [1:0]               state_out_o,
  output logic [COUNT_WIDTH-1:0]   trig_count_o,
  output logic                     lock_lost_o
);

  localparam int LCW = (LOCK_FILTER < 1) ? 1 : $clog2(LOCK_FILTER + 1);
  localparam logic [LCW-1:0]           C_LCNT_MAX = LCW'(LOCK_FILTER);
  localparam logic [LCW-1:0]           C_LCNT_ONE = LCW'(1);
  localparam logic [HOLDOFF_WIDTH-1:0] C_HCNT_ONE = HOLDOFF_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]   C_CNT_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_ARMED     = 2'd2,
    ST_HOLDOFF   = 2'd3
  } state_t;

  state_t                   state_q;
  logic [LCW-1:0]           lcnt_q;
  logic [LCW-1:0]           lcnt_d;
  logic [HOLDOFF_WIDTH-1:0] hcnt_q;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic                     trig_q;
  logic                     lost_q;
  logic                     mode_q;

  logic w_sel_lock;
  logic w_mode_chg;
  logic w_lock_ok;
  logic w_hit;
  logic w_fire;
  logic w_lost_set;

  assign w_sel_lock = cfg_mode_i ? lock_64b66b_i : lock_8b10b_i;
  assign w_mode_chg = (cfg_mode_i != mode_q);
  assign w_lock_ok  = w_sel_lock && (lcnt_q == C_LCNT_MAX) && !w_mode_chg;
  assign w_hit      = match_valid_i && match_hit_i;

  // Disarm outranks lock loss, which outranks a hit.
  assign w_fire     = (state_q == ST_ARMED) && !disarm_i && w_lock_ok && w_hit;
  assign w_lost_set = ((state_q == ST_ARMED) || (state_q == ST_HOLDOFF)) &&
                      !disarm_i && !w_lock_ok;

  always_comb begin
    lcnt_d = lcnt_q;
    if (!w_sel_lock || w_mode_chg) begin
      lcnt_d = '0;
    end else if (lcnt_q != C_LCNT_MAX) begin
      lcnt_d = lcnt_q + C_LCNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lcnt_q  <= '0;
      hcnt_q  <= '0;
      count_q <= '0;
      trig_q  <= 1'b0;
      lost_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      mode_q <= cfg_mode_i;
      trig_q <= w_fire;

      if (clear_status_i) begin
        count_q <= '0;
        lost_q  <= 1'b0;
      end else begin
        if (w_fire && (count_q != {COUNT_WIDTH{1'b1}})) begin
          count_q <= count_q + C_CNT_ONE;
        end
        if (w_lost_set) begin
          lost_q <= 1'b1;
        end
      end

      if (disarm_i) begin
        state_q <= ST_IDLE;
        hcnt_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm_i) begin
              state_q <= ST_WAIT_LOCK;
            end
          end
          ST_WAIT_LOCK: begin
            if (w_lock_ok) begin
              state_q <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (!w_lock_ok) begin
              state_q <= ST_WAIT_LOCK;
            end else if (w_hit) begin
              if (cfg_oneshot_i) begin
                state_q <= ST_IDLE;
              end else if (cfg_holdoff_i != '0) begin
                state_q <= ST_HOLDOFF;
                hcnt_q  <= cfg_holdoff_i;
              end
            end
          end
          ST_HOLDOFF: begin
            if (!w_lock_ok) begin
              state_q <= ST_WAIT_LOCK;
              hcnt_q  <= '0;
            end else if (hcnt_q == C_HCNT_ONE) begin
              state_q <= ST_ARMED;
              hcnt_q  <= '0;
            end else begin
              hcnt_q <= hcnt_q - C_HCNT_ONE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign trig_out_o     = trig_q;
  assign armed_o        = (state_q == ST_ARMED);
  assign waiting_lock_o = (state_q == ST_WAIT_LOCK);
  assign state_out_o    = state_q;
  assign trig_count_o   = count_q;
  assign lock_lost_o    = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_cdr_trigger_arm_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_cdr_trigger_arm_ctrl : scoreboard bench with a behavioural reference model
// Rev 1.0
// ============================================================================
module tb_cdr_trigger_arm_ctrl;

  localparam int LF  = 8;
  localparam int HW  = 8;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_ARMED = 2;
  localparam int M_HOLD  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_mode = 1'b0;
  logic          cfg_oneshot = 1'b0;
  logic [HW-1:0] cfg_holdoff = '0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic          clear_status = 1'b0;
  logic          lock_8b10b = 1'b1;
  logic          lock_64b66b = 1'b0;
  logic          match_valid = 1'b0;
  logic          match_hit = 1'b0;

  logic          trig_out;
  logic          armed;
  logic          waiting_lock;
  logic [1:0]    state_out;
  logic [CW-1:0] trig_count;
  logic          lock_lost;

  cdr_trigger_arm_ctrl #(
    .LOCK_FILTER  (LF),
    .HOLDOFF_WIDTH(HW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_mode_i     (cfg_mode),
    .cfg_oneshot_i  (cfg_oneshot),
    .cfg_holdoff_i  (cfg_holdoff),
    .arm_i          (arm),
    .disarm_i       (disarm),
    .clear_status_i (clear_status),
    .lock_8b10b_i   (lock_8b10b),
    .lock_64b66b_i  (lock_64b66b),
    .match_valid_i  (match_valid),
    .match_hit_i    (match_hit),
    .trig_out_o     (trig_out),
    .armed_o        (armed),
    .waiting_lock_o (waiting_lock),
    .state_out_o    (state_out),
    .trig_count_o   (trig_count),
    .lock_lost_o    (lock_lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          trig;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic          lost;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: lock is tracked as the length of the current unbroken run
  // of the selected lock source; holdoff as the number of dead cycles left.
  int   m_state = M_IDLE;
  int   m_run   = 0;
  int   m_hrem  = 0;
  int   m_cnt   = 0;
  bit   m_lost  = 0;
  bit   m_trig  = 0;
  bit   m_prev_mode = 0;

  task automatic model_step();
    bit sel, chg, ok, hit, fire, drop;
    if (rst) begin
      m_state = M_IDLE; m_run = 0; m_hrem = 0; m_cnt = 0;
      m_lost = 0; m_trig = 0; m_prev_mode = 0;
      return;
    end
    sel  = cfg_mode ? lock_64b66b : lock_8b10b;
    chg  = (cfg_mode != m_prev_mode);
    ok   = sel && !chg && (m_run >= LF);
    hit  = match_valid && match_hit;
    fire = 0;
    drop = 0;
    if (disarm) begin
      m_state = M_IDLE;
      m_hrem  = 0;
    end else begin
      case (m_state)
        M_IDLE:  if (arm) m_state = M_WAIT;
        M_WAIT:  if (ok) m_state = M_ARMED;
        M_ARMED: begin
          if (!ok) begin
            drop = 1; m_state = M_WAIT;
          end else if (hit) begin
            fire = 1;
            if (cfg_oneshot) m_state = M_IDLE;
            else if (cfg_holdoff != 0) begin
              m_state = M_HOLD; m_hrem = int'(cfg_holdoff);
            end
          end
        end
        default: begin
          if (!ok) begin
            drop = 1; m_state = M_WAIT;
          end else begin
            m_hrem = m_hrem - 1;
            if (m_hrem == 0) m_state = M_ARMED;
          end
        end
      endcase
    end
    m_trig = fire;
    m_run  = (!sel || chg) ? 0 : ((m_run < 1000) ? m_run + 1 : m_run);
    m_prev_mode = cfg_mode;
    if (clear_status) begin
      m_cnt = 0; m_lost = 0;
    end else begin
      if (fire && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (drop) m_lost = 1;
    end
  endtask

  // Inputs are applied at a falling edge; the expected post-edge outputs queue up.
  task automatic tick();
    exp_t e;
    model_step();
    e.trig = m_trig;
    e.st   = 2'(m_state);
    e.cnt  = CW'(m_cnt);
    e.lost = m_lost;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("trig_out",     int'(trig_out),     int'(e.trig));
        chk("state_out",    int'(state_out),    int'(e.st));
        chk("trig_count",   int'(trig_count),   int'(e.cnt));
        chk("lock_lost",    int'(lock_lost),    int'(e.lost));
        chk("armed",        int'(armed),        int'(e.st == 2'd2));
        chk("waiting_lock", int'(waiting_lock), int'(e.st == 2'd1));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic hits(input int n);
    match_valid = 1; match_hit = 1;
    repeat (n) tick();
    match_valid = 0; match_hit = 0;
  endtask

  task automatic pulse_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic pulse_disarm();
    disarm = 1; tick(); disarm = 0;
  endtask

  initial begin : stim
    @(negedge clk);
    rst = 1;
    repeat (3) tick();
    rst = 0;

    // arm, lock qualifies, single hit
    pulse_arm();
    repeat (10) tick();
    hits(1);
    repeat (3) tick();

    // holdoff of 3 with continuous hits
    cfg_holdoff = 8'd3;
    hits(12);
    repeat (2) tick();

    // one-shot: a single trigger then ignored hits
    pulse_disarm();
    clear_status = 1; tick(); clear_status = 0;
    cfg_oneshot = 1; cfg_holdoff = 0;
    pulse_arm();
    repeat (10) tick();
    hits(11);
    cfg_oneshot = 0;

    // lock drop coincident with hit, then relock
    pulse_arm();
    repeat (10) tick();
    lock_8b10b = 0; match_valid = 1; match_hit = 1; tick();
    lock_8b10b = 1; match_valid = 0; match_hit = 0;
    repeat (10) tick();

    // disarm with coincident hit
    disarm = 1; match_valid = 1; match_hit = 1; tick();
    disarm = 0; match_valid = 0; match_hit = 0;
    tick();

    // mode toggle while armed
    lock_64b66b = 1;
    pulse_arm();
    repeat (10) tick();
    cfg_mode = 1; tick();
    repeat (10) tick();

    // saturation with zero holdoff, then clear coincident with a hit
    cfg_holdoff = 0;
    hits(20);
    clear_status = 1; match_valid = 1; match_hit = 1; tick();
    clear_status = 0; match_valid = 0; match_hit = 0;
    repeat (3) tick();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      arm          = ($urandom_range(0, 7) == 0);
      disarm       = ($urandom_range(0, 39) == 0);
      clear_status = ($urandom_range(0, 49) == 0);
      lock_8b10b   = ($urandom_range(0, 29) != 0);
      lock_64b66b  = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 149) == 0) cfg_mode = ~cfg_mode;
      if ($urandom_range(0, 99) == 0) cfg_oneshot = ~cfg_oneshot;
      if ($urandom_range(0, 19) == 0) cfg_holdoff = HW'($urandom_range(0, 5));
      match_valid  = 1'($urandom);
      match_hit    = 1'($urandom);
      tick();
    end
    rst = 0; arm = 0; disarm = 0; clear_status = 0;
    match_valid = 0; match_hit = 0;
    repeat (2) tick();

    #2;
    chk("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
